// File: rtl/sp_ram_arb.sv
// Two-master round-robin request/grant front end for sp_ram_wrap.
// One RAM access per cycle; per-port response (rvalid/err/rdata) one cycle after grant.
module sp_ram_arb #(
    parameter int          RAM_SIZE   = 32768,
    parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
    input  logic                    clk,
    input  logic                    rst_i,

    input  logic                    p0_req_i,
    input  logic [31:0]             p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic                    p0_err_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,

    input  logic                    p1_req_i,
    input  logic [31:0]             p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic                    p1_err_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,

    input  logic                    bypass_i,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic                    ram_bypass_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_W = DATA_WIDTH / 8;

    function automatic logic in_range(input logic [31:0] a);
        return a[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH];
    endfunction

    logic                  prio_q;
    logic                  rvalid_q;
    logic                  err_q;
    logic                  rid_q;
    logic                  rd_q;

    logic                  gnt0;
    logic                  gnt1;
    logic                  gnt_any;
    logic                  sel;
    logic [31:0]           addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  hit;

    // Arbitration: a lone request wins outright, contention goes to prio_q.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i) begin
            if (p0_req_i && p1_req_i) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = p0_req_i;
                gnt1 = p1_req_i;
            end
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign sel     = gnt1;
    assign addr    = sel ? p1_addr_i  : p0_addr_i;
    assign we      = sel ? p1_we_i    : p0_we_i;
    assign be      = sel ? p1_be_i    : p0_be_i;
    assign wdata   = sel ? p1_wdata_i : p0_wdata_i;
    assign hit     = gnt_any & in_range(addr);

    assign p0_gnt_o     = gnt0;
    assign p1_gnt_o     = gnt1;
    assign ram_en_o     = hit;
    assign ram_we_o     = hit & we;
    assign ram_be_o     = hit ? be : '0;
    assign ram_addr_o   = addr[ADDR_WIDTH-1:0];
    assign ram_wdata_o  = wdata;
    assign ram_bypass_o = bypass_i;

    // Response stage: remembers who was granted and whether data comes back from the RAM.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            prio_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rid_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            rvalid_q <= gnt_any;
            err_q    <= gnt_any & ~in_range(addr);
            rd_q     <= hit & ~we;
            if (gnt_any) begin
                prio_q <= ~sel;
                rid_q  <= sel;
            end
        end
    end

    assign p0_rvalid_o = ~rst_i & rvalid_q & ~rid_q;
    assign p1_rvalid_o = ~rst_i & rvalid_q & rid_q;
    assign p0_err_o    = p0_rvalid_o & err_q;
    assign p1_err_o    = p1_rvalid_o & err_q;
    assign p0_rdata_o  = (p0_rvalid_o & rd_q) ? ram_rdata_i : '0;
    assign p1_rdata_o  = (p1_rvalid_o & rd_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_sp_ram_arb.sv
// Bench for sp_ram_arb: directed scenarios plus random two-master traffic, checked
// cycle by cycle against a transaction-level model of arbitration, decode and memory.
module tb_sp_ram_arb;

    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        p0_req_i, p1_req_i, p0_we_i, p1_we_i;
    logic [31:0] p0_addr_i, p1_addr_i, p0_wdata_i, p1_wdata_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic        p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, p0_err_o, p1_err_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        bypass_i, ram_en_o, ram_we_o, ram_bypass_o;
    logic [14:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_rdata_i = '0;

    always #5 clk = ~clk;

    sp_ram_arb dut (
        .clk(clk), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
        .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
        .p0_err_o(p0_err_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
        .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
        .p1_err_o(p1_err_o), .p1_rdata_o(p1_rdata_o),
        .bypass_i(bypass_i), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_bypass_o(ram_bypass_o), .ram_rdata_i(ram_rdata_i)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5C3_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Stand-in for sp_ram_wrap: 16 words, suppresses writes under bypass, 1-cycle read.
    logic [31:0] ram_mem [16];
    initial for (int i = 0; i < 16; i++) ram_mem[i] = init_word(i);
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                if (!ram_bypass_o)
                    for (int b = 0; b < 4; b++)
                        if (ram_be_o[b]) ram_mem[ram_addr_o[5:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata_i <= ram_mem[ram_addr_o[5:2]];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Stimulus state per port and the reference model.
    logic        req [2];
    logic [31:0] addr [2];
    logic        we [2];
    logic [3:0]  be [2];
    logic [31:0] wdata [2];
    logic        rst_s, byp_s;

    logic [31:0] mem [16];
    int          prio;
    logic        pend_v;
    int          pend_id;
    logic        pend_err;
    logic [31:0] pend_rdata;
    int          last_g;

    function automatic logic model_in_range(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h8000);
    endfunction

    task automatic step();
        int          g;
        logic        inr;
        logic [31:0] exp_rd [2];
        @(negedge clk);
        rst_i = rst_s; bypass_i = byp_s;
        p0_req_i = req[0]; p0_addr_i = addr[0]; p0_we_i = we[0]; p0_be_i = be[0]; p0_wdata_i = wdata[0];
        p1_req_i = req[1]; p1_addr_i = addr[1]; p1_we_i = we[1]; p1_be_i = be[1]; p1_wdata_i = wdata[1];
        #1;
        g = -1;
        if (!rst_s) begin
            if (req[0] && req[1]) g = prio;
            else if (req[0])      g = 0;
            else if (req[1])      g = 1;
        end
        inr = (g >= 0) && model_in_range(addr[g]);
        check("p0_gnt", {31'd0, p0_gnt_o}, {31'd0, g == 0});
        check("p1_gnt", {31'd0, p1_gnt_o}, {31'd0, g == 1});
        check("ram_en", {31'd0, ram_en_o}, {31'd0, inr});
        check("ram_we", {31'd0, ram_we_o}, {31'd0, inr && we[g]});
        check("ram_bypass", {31'd0, ram_bypass_o}, {31'd0, byp_s});
        if (g < 0) check("ram_be_idle", {28'd0, ram_be_o}, 32'd0);
        if (inr) begin
            check("ram_addr", {17'd0, ram_addr_o}, {17'd0, addr[g][14:0]});
            check("ram_be", {28'd0, ram_be_o}, {28'd0, be[g]});
            if (we[g]) check("ram_wdata", ram_wdata_o, wdata[g]);
        end
        for (int p = 0; p < 2; p++)
            exp_rd[p] = (!rst_s && pend_v && pend_id == p) ? pend_rdata : 32'd0;
        check("p0_rvalid", {31'd0, p0_rvalid_o}, {31'd0, !rst_s && pend_v && pend_id == 0});
        check("p1_rvalid", {31'd0, p1_rvalid_o}, {31'd0, !rst_s && pend_v && pend_id == 1});
        check("p0_err", {31'd0, p0_err_o}, {31'd0, !rst_s && pend_v && pend_id == 0 && pend_err});
        check("p1_err", {31'd0, p1_err_o}, {31'd0, !rst_s && pend_v && pend_id == 1 && pend_err});
        check("p0_rdata", p0_rdata_o, exp_rd[0]);
        check("p1_rdata", p1_rdata_o, exp_rd[1]);
        // Advance the model to the next cycle.
        last_g = g;
        if (rst_s) begin
            prio = 0;
            pend_v = 1'b0;
        end else if (g >= 0) begin
            prio = 1 - g;
            pend_v = 1'b1;
            pend_id = g;
            pend_err = !inr;
            pend_rdata = (inr && !we[g]) ? mem[addr[g][5:2]] : 32'd0;
            if (inr && we[g] && !byp_s)
                for (int b = 0; b < 4; b++)
                    if (be[g][b]) mem[addr[g][5:2]][8*b +: 8] = wdata[g][8*b +: 8];
        end else begin
            pend_v = 1'b0;
        end
    endtask

    task automatic set_txn(input int p, input logic r, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
        req[p] = r; addr[p] = a; we[p] = w; be[p] = b; wdata[p] = d;
    endtask

    task automatic rand_txn(input int p);
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = 32'h0020_0000 + {$urandom_range(0, 15), 2'b00};
            1:       a = BASE + 32'h8000;
            2:       a = BASE - 32'd4;
            default: a = BASE + {$urandom_range(0, 15), 2'b00};
        endcase
        set_txn(p, $urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1,
                4'($urandom_range(1, 15)), $urandom);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = init_word(i);
        prio = 0; pend_v = 1'b0; pend_id = 0; pend_err = 1'b0; pend_rdata = '0; last_g = -1;
        byp_s = 1'b0;

        // Reset with both masters requesting, then release: p0 first.
        rst_s = 1'b1;
        set_txn(0, 1'b1, BASE + 32'h4, 1'b0, 4'hF, 32'd0);
        set_txn(1, 1'b1, BASE + 32'h8, 1'b0, 4'hF, 32'd0);
        step(); step();
        rst_s = 1'b0;
        // Contention: both hold reads for four cycles, grants alternate.
        repeat (4) step();
        set_txn(0, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        set_txn(1, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        step();

        // p1 partial write, then p0 read of the same word.
        set_txn(1, 1'b1, 32'h0010_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        step();
        set_txn(1, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        set_txn(0, 1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'd0);
        step();
        set_txn(0, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        step();
        check("wr_rd_low_half", {16'd0, mem[4][15:0]}, 32'h0000_BEEF);

        // Out-of-range read.
        set_txn(0, 1'b1, 32'h0020_0000, 1'b0, 4'hF, 32'd0);
        step();
        set_txn(0, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        step();

        // Write under bypass is acknowledged but leaves the RAM alone.
        byp_s = 1'b1;
        set_txn(0, 1'b1, BASE, 1'b1, 4'hF, 32'h0000_0001);
        step();
        byp_s = 1'b0;
        set_txn(0, 1'b1, BASE, 1'b0, 4'hF, 32'd0);
        step();
        set_txn(0, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        step();

        // Reset right after p1 is granted: its response is lost and priority returns to p0.
        set_txn(1, 1'b1, BASE + 32'hC, 1'b0, 4'hF, 32'd0);
        step();
        set_txn(1, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        step();
        set_txn(0, 1'b1, BASE + 32'h4, 1'b0, 4'hF, 32'd0);
        set_txn(1, 1'b1, BASE + 32'h8, 1'b0, 4'hF, 32'd0);
        step();
        check("prio_after_reset", last_g, 0);
        step();

        // Random traffic; ungranted requests stay stable until granted.
        rand_txn(0); rand_txn(1);
        for (int c = 0; c < 600; c++) begin
            rst_s = ($urandom_range(0, 59) == 0);
            byp_s = ($urandom_range(0, 9) == 0);
            step();
            for (int p = 0; p < 2; p++)
                if (last_g == p || !req[p]) rand_txn(p);
        end
        rst_s = 1'b0;
        set_txn(0, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        set_txn(1, 1'b0, BASE, 1'b0, 4'hF, 32'd0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
